mem_stage_lsu: RTL
==================

# mem_stage_lsu

Parametrised memory-access stage of the 5-stage pipeline, between the EX/MEM boundary and write-back. It registers non-memory results to WB with one cycle of latency. It also executes byte, halfword and word loads and stores against a data memory with a req/ack handshake, stalling upstream while an access is outstanding. A bus timeout reports an error instead of hanging the pipeline, and an optional alignment checker flags misaligned accesses.

## Interface
- ADDR_W, 32, data-memory byte address width
- REGADDR_W, 5, destination register index width
- TIMEOUT, 16, max cycles `dmem_req_o` is held without ack before abort; 0 = never time out

- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- valid_i  in  1  EX slot holds an instruction
- ready_o  out  1  stage can accept (state IDLE)
- wd_i  in  REGADDR_W  destination register
- wreg_i  in  1  register write enable
- wdata_i  in  32  ALU result
- memop_i  in  4  memory op (NONE, LB, LBU, LH, LHU, LW, SB, SH, SW)
- mem_addr_i  in  ADDR_W  effective address
- mem_wdata_i  in  32  store data
- dmem_req_o  out  1  access request, held until ack or timeout
- dmem_we_o  out  1  1 = store
- dmem_addr_o  out  ADDR_W  word-aligned address (low 2 bits 0)
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-positioned store data
- dmem_ack_i  in  1  access complete; `dmem_rdata_i` valid for loads
- dmem_rdata_i  in  32  load word
- valid_o  out  1  one-cycle pulse, result to WB
- wd_o  out  REGADDR_W  to WB
- wreg_o  out  1  to WB
- wdata_o  out  32  to WB
- err_o  out  1  bus timeout, qualified by `valid_o`
- misalign_o  out  1  misaligned access, qualified by `valid_o`
- badaddr_o  out  ADDR_W  faulting address when `err_o` or `misalign_o`

## Operation
- FSM states: IDLE, REQ.
- `ready_o` = (state == IDLE).
- Accept = `valid_i && ready_o`.
- Accept with memop NONE: registered pass-through. `valid_o` = 1 next cycle with `wd_i`, `wreg_i`, `wdata_i`. State stays IDLE.
- Accept with a memory op:
  - latch the op, register index, write enable, address and store data;
  - → REQ;
  - drive `dmem_*` from registers.
- In REQ:
  - on `dmem_ack_i`, load: extract the lane, sign-extend (LB, LH) or zero-extend (LBU, LHU); `wdata_o` = result, `wreg_o` = latched `wreg_i`.
  - on `dmem_ack_i`, store: `wreg_o` = 0.
  - after ack: `valid_o` pulses, → IDLE.
- Little-endian lanes:
  - SB: `be` = 1<<addr[1:0], byte replicated ×4.
  - SH: `be` = 0011 if addr[1]=0, else 1100; half replicated ×2.
  - SW: `be` = 1111.
  - Loads use the same lane select.
- Timeout: a wait counter clears on entering REQ and increments per REQ cycle without ack. When it reaches TIMEOUT, drop `dmem_req_o`, pulse `valid_o` with `err_o` = 1, `wreg_o` = 0, `badaddr_o` = address; → IDLE.
- Timeout priority: ack in the cycle the counter hits TIMEOUT wins, giving a normal completion.
- Counter width: clog2(TIMEOUT+1).
- `valid_i` while not ready: ignored. Upstream holds its inputs.
- `dmem_ack_i` in IDLE: ignored.

## Timing
- Reset (async assert, any state): state IDLE, counter 0, `dmem_req_o` = 0, all outputs 0 (`wd_o` = NOP register 0).
- Reset mid-REQ abandons the access; no `valid_o`.
- Non-memory latency: 1 cycle, back-to-back throughput 1/cycle.
- Memory access:
  - accept at edge E0 → `dmem_req_o` high from E0.
  - ack sampled at edge Ek → `valid_o` high cycle after Ek.
  - `ready_o` high again cycle after Ek, so the next accept can occur at Ek+1.
  - Minimum load-to-WB: 2 cycles.
- `dmem_addr_o`, `dmem_be_o`, `dmem_wdata_o` and `dmem_we_o` are stable for the whole REQ period.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - LH/LHU/SH with addr[0] ≠ 0, or LW/SW with addr[1:0] ≠ 0, issue no request.
  - `valid_o` + `misalign_o` = 1 next cycle, `wreg_o` = 0, `badaddr_o` = address. State stays IDLE.
- Undefined:
  - `misalign_o` tied 0;
  - misaligned halfwords use addr[1] and ignore addr[0];
  - words ignore addr[1:0].

## Structure
- Package `mem_pkg`: memop encodings, data width 32, NOP register address, byte-enable constants.
- Sub-module `mem_lsu_align` (combinational): store lane placement and `be` generation; load lane extract and extension.

## Test plan
- NONE ops `wd`=3, `wdata`=0x1234 on 3 consecutive cycles → `valid_o` 3 consecutive cycles, 1-cycle latency, `ready_o` constant 1.
- LB at addr 0x...03, `rdata`=0x80FF_FF7F, ack after 2 wait cycles → `wdata_o`=0xFFFF_FF80, `valid_o` 4 cycles after accept; LBU → 0x0000_0080.
- SH at addr 0x...02, data 0xABCD, ack same cycle → `be`=1100, `dmem_wdata_o`=0xABCD_ABCD, `wreg_o`=0.
- No ack, TIMEOUT=4 → `dmem_req_o` high 4 cycles, then `valid_o`+`err_o`, `badaddr_o` = address. Also ack on the 4th cycle → normal completion, `err_o`=0.
- With `MEM_ALIGN_CHECK_EN`: LW at 0x...02 → no `dmem_req_o`, `misalign_o`=1 next cycle. Without it: request to 0x...00, `be`=1111.
- `rst` low while in REQ → `dmem_req_o` drops asynchronously, no `valid_o`; after release, a NONE op completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_pkg                                                                    |
// | Shared encodings for the memory-access stage: memop codes, data width,     |
// | NOP register index and byte-enable constants.                             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mem_pkg;

  localparam int DATA_W  = 32;
  localparam int NOP_REG = 0;

  typedef enum logic [3:0] {
    MEMOP_NONE = 4'd0,
    MEMOP_LB   = 4'd1,
    MEMOP_LBU  = 4'd2,
    MEMOP_LH   = 4'd3,
    MEMOP_LHU  = 4'd4,
    MEMOP_LW   = 4'd5,
    MEMOP_SB   = 4'd6,
    MEMOP_SH   = 4'd7,
    MEMOP_SW   = 4'd8
  } memop_e;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  function automatic logic is_memop(input memop_e op);
    return (op == MEMOP_LB) || (op == MEMOP_LBU) || (op == MEMOP_LH) ||
           (op == MEMOP_LHU) || (op == MEMOP_LW) || (op == MEMOP_SB) ||
           (op == MEMOP_SH) || (op == MEMOP_SW);
  endfunction

  function automatic logic is_store(input memop_e op);
    return (op == MEMOP_SB) || (op == MEMOP_SH) || (op == MEMOP_SW);
  endfunction

  function automatic logic is_misaligned(input memop_e op, input logic [1:0] lo);
    logic half, word;
    half = (op == MEMOP_LH) || (op == MEMOP_LHU) || (op == MEMOP_SH);
    word = (op == MEMOP_LW) || (op == MEMOP_SW);
    return (half && lo[0]) || (word && (lo != 2'b00));
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lsu_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_lsu_align                                                              |
// | Combinational little-endian lane logic: store byte enables and data        |
// | placement, load lane extraction with sign/zero extension.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_lsu_align
  import mem_pkg::*;
(
  input  memop_e      op_i,
  input  logic [1:0]  lo_i,
  input  logic [31:0] sdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);

  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_shifted = rdata_i >> {lo_i, 3'b000};
    w_byte    = w_shifted[7:0];
    // halfwords select on addr[1] only; addr[0] is ignored here
    w_half    = lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    be_o    = BE_NONE;
    wdata_o = sdata_i;
    ldata_o = '0;
    case (op_i)
      MEMOP_LB:  begin be_o = BE_BYTE0 << lo_i; ldata_o = {{24{w_byte[7]}}, w_byte}; end
      MEMOP_LBU: begin be_o = BE_BYTE0 << lo_i; ldata_o = {24'd0, w_byte}; end
      MEMOP_LH:  begin be_o = lo_i[1] ? BE_HI_HALF : BE_LO_HALF; ldata_o = {{16{w_half[15]}}, w_half}; end
      MEMOP_LHU: begin be_o = lo_i[1] ? BE_HI_HALF : BE_LO_HALF; ldata_o = {16'd0, w_half}; end
      MEMOP_LW:  begin be_o = BE_WORD; ldata_o = rdata_i; end
      MEMOP_SB:  begin be_o = BE_BYTE0 << lo_i; wdata_o = {4{sdata_i[7:0]}}; end
      MEMOP_SH:  begin be_o = lo_i[1] ? BE_HI_HALF : BE_LO_HALF; wdata_o = {2{sdata_i[15:0]}}; end
      MEMOP_SW:  be_o = BE_WORD;
      default:   be_o = BE_NONE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_stage_lsu                                                              |
// | Pipeline MEM stage: registered pass-through of ALU results and req/ack     |
// | data-memory loads/stores with bus timeout. Optional alignment checker      |
// | enabled by defining MEM_ALIGN_CHECK_EN.                                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_stage_lsu
  import mem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int REGADDR_W = 5,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [REGADDR_W-1:0] wd_i,
  input  logic                 wreg_i,
  input  logic [DATA_W-1:0]    wdata_i,
  input  logic [3:0]           memop_i,
  input  logic [ADDR_W-1:0]    mem_addr_i,
  input  logic [DATA_W-1:0]    mem_wdata_i,
  output logic                 dmem_req_o,
  output logic                 dmem_we_o,
  output logic [ADDR_W-1:0]    dmem_addr_o,
  output logic [3:0]           dmem_be_o,
  output logic [DATA_W-1:0]    dmem_wdata_o,
  input  logic                 dmem_ack_i,
  input  logic [DATA_W-1:0]    dmem_rdata_i,
  output logic                 valid_o,
  output logic [REGADDR_W-1:0] wd_o,
  output logic                 wreg_o,
  output logic [DATA_W-1:0]    wdata_o,
  output logic                 err_o,
  output logic                 misalign_o,
  output logic [ADDR_W-1:0]    badaddr_o
);

  localparam int              CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic            TMO_EN   = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  memop_e                 op_q, op_d;
  logic [REGADDR_W-1:0]   lwd_q, lwd_d;
  logic                   lwreg_q, lwreg_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      sdata_q, sdata_d;
  logic                   valid_q, valid_d;
  logic [REGADDR_W-1:0]   wd_q, wd_d;
  logic                   wreg_q, wreg_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic                   err_q, err_d;
  logic                   misalign_q, misalign_d;
  logic [ADDR_W-1:0]      badaddr_q, badaddr_d;

  memop_e                 w_op_in;
  logic                   w_accept;
  logic                   w_misalign;
  logic [DATA_W-1:0]      w_ldata;

  mem_lsu_align u_align (
    .op_i    (op_q),
    .lo_i    (addr_q[1:0]),
    .sdata_i (sdata_q),
    .rdata_i (dmem_rdata_i),
    .be_o    (dmem_be_o),
    .wdata_o (dmem_wdata_o),
    .ldata_o (w_ldata)
  );

  assign w_op_in  = memop_e'(memop_i);
  assign w_accept = valid_i && (state_q == S_IDLE);

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = is_misaligned(w_op_in, mem_addr_i[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    lwd_d      = lwd_q;
    lwreg_d    = lwreg_q;
    addr_d     = addr_q;
    sdata_d    = sdata_q;
    valid_d    = 1'b0;
    wd_d       = wd_q;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    misalign_d = misalign_q;
    badaddr_d  = badaddr_q;

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          if (!is_memop(w_op_in)) begin
            valid_d    = 1'b1;
            wd_d       = wd_i;
            wreg_d     = wreg_i;
            wdata_d    = wdata_i;
            err_d      = 1'b0;
            misalign_d = 1'b0;
            badaddr_d  = '0;
          end else if (w_misalign) begin
            valid_d    = 1'b1;
            wd_d       = wd_i;
            wreg_d     = 1'b0;
            wdata_d    = '0;
            err_d      = 1'b0;
            misalign_d = 1'b1;
            badaddr_d  = mem_addr_i;
          end else begin
            op_d    = w_op_in;
            lwd_d   = wd_i;
            lwreg_d = wreg_i;
            addr_d  = mem_addr_i;
            sdata_d = mem_wdata_i;
            cnt_d   = '0;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        // ack outranks a timeout landing on the same edge
        if (dmem_ack_i) begin
          valid_d    = 1'b1;
          wd_d       = lwd_q;
          wreg_d     = lwreg_q && !is_store(op_q);
          wdata_d    = is_store(op_q) ? '0 : w_ldata;
          err_d      = 1'b0;
          misalign_d = 1'b0;
          badaddr_d  = '0;
          state_d    = S_IDLE;
        end else if (TMO_EN && (cnt_q == CNT_LAST)) begin
          valid_d    = 1'b1;
          wd_d       = lwd_q;
          wreg_d     = 1'b0;
          wdata_d    = '0;
          err_d      = 1'b1;
          misalign_d = 1'b0;
          badaddr_d  = addr_q;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= MEMOP_NONE;
      lwd_q      <= '0;
      lwreg_q    <= 1'b0;
      addr_q     <= '0;
      sdata_q    <= '0;
      valid_q    <= 1'b0;
      wd_q       <= REGADDR_W'(NOP_REG);
      wreg_q     <= 1'b0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      misalign_q <= 1'b0;
      badaddr_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      lwd_q      <= lwd_d;
      lwreg_q    <= lwreg_d;
      addr_q     <= addr_d;
      sdata_q    <= sdata_d;
      valid_q    <= valid_d;
      wd_q       <= wd_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      misalign_q <= misalign_d;
      badaddr_q  <= badaddr_d;
    end
  end

  assign ready_o     = (state_q == S_IDLE);
  assign dmem_req_o  = (state_q == S_REQ);
  assign dmem_we_o   = is_store(op_q);
  assign dmem_addr_o = {addr_q[ADDR_W-1:2], 2'b00};
  assign valid_o     = valid_q;
  assign wd_o        = wd_q;
  assign wreg_o      = wreg_q;
  assign wdata_o     = wdata_q;
  assign err_o       = err_q;
  assign misalign_o  = misalign_q;
  assign badaddr_o   = badaddr_q;

endmodule
`default_nettype wire
